addsub_serial_unit: RTL and testbench

//   Multi-cycle, parametrised successor of the 32-bit combinational add/sub unit. Computes
//   a+b, a-b, -b or b+1 over WIDTH bits, SLICE bits per clock, with a carry register between

---
 rtl/addsub_serial_unit_pkg.sv | 30 +++
 rtl/addsub_serial_unit_if.sv | 27 ++
 rtl/addsub_serial_unit_slice.sv | 24 ++
 rtl/addsub_serial_unit.sv | 172 +++++++++++++++++
 tb/tb_addsub_serial_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_serial_unit_pkg.sv
// Shared definitions for the serial add/sub unit: function codes, FSM states
// and operand-conditioning helpers.
package addsub_serial_unit_pkg;

    localparam int unsigned F_W = 2;

    typedef enum logic [F_W-1:0] {
        F_ADD = 2'b00,
        F_SUB = 2'b01,
        F_NEG = 2'b10,
        F_INC = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // b is inverted for SUB and NEG
    function automatic logic invert_b(input logic [F_W-1:0] f);
        return f[1] ^ f[0];
    endfunction

    // Carry-in of the first slice; only ADD starts with zero
    function automatic logic carry_in(input logic [F_W-1:0] f);
        return f[1] | f[0];
    endfunction

endpackage

// File: rtl/addsub_serial_unit_if.sv
// Operand/result handshake bundle of the serial add/sub unit.
interface addsub_serial_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             n_flag;
    logic             z_flag;
    logic             O;

    modport master (
        output in_valid, a, b, f, out_ready,
        input  in_ready, out_valid, s, c_out, n_flag, z_flag, O
    );

    modport slave (
        input  in_valid, a, b, f, out_ready,
        output in_ready, out_valid, s, c_out, n_flag, z_flag, O
    );
endinterface

// File: rtl/addsub_serial_unit_slice.sv
// Combinational SLICE-bit ripple-carry adder used once per clock by the serial unit.
module addsub_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_serial_unit.sv
// Multi-cycle add/sub/negate/increment unit: WIDTH-bit result computed SLICE bits
// per clock, LSB slice first, with N/Z/C/O flags and valid/ready on both sides.
module addsub_serial_unit
    import addsub_serial_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    addsub_serial_unit_if.slave bus
);

    localparam int unsigned NSL  = WIDTH / SLICE;
    localparam int unsigned IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int unsigned MSB  = WIDTH - 1;

    if ((WIDTH < 2) || (SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_param_check
        $error("addsub_serial_unit: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              o_q, o_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [SLICE-1:0]       sl_s;
    logic                   sl_cout;
    logic [WIDTH-1:0]       a_cond;
    logic [WIDTH-1:0]       b_cond;
    logic [WIDTH+SLICE-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   z_next;

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sh_q[SLICE-1:0]),
        .b    (b_sh_q[SLICE-1:0]),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Operand conditioning applied once, at the accept edge
    always_comb begin
        a_cond = bus.f[1] ? '0 : bus.a;
        b_cond = bus.b ^ {WIDTH{invert_b(bus.f)}};
    end

    // New slice enters at the top of the result shift register
    always_comb begin
        res_cat  = {sl_s, res_q};
        res_next = WIDTH'(res_cat >> SLICE);
        z_next   = zacc_q & ~(|sl_s);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        s_d       = s_q;
        c_d       = c_q;
        z_d       = z_q;
        n_d       = n_q;
        o_d       = o_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = a_cond;
                    b_sh_d  = b_cond;
                    a_msb_d = a_cond[MSB];
                    b_msb_d = b_cond[MSB];
                    carry_d = carry_in(bus.f);
                    zacc_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> SLICE;
                b_sh_d  = b_sh_q >> SLICE;
                res_d   = res_next;
                carry_d = sl_cout;
                zacc_d  = z_next;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NSL - 1)) begin
                    s_d     = res_next;
                    c_d     = sl_cout;
                    z_d     = z_next;
                    n_d     = res_next[MSB];
                    o_d     = (~a_msb_q & ~b_msb_q &  res_next[MSB]) |
                              ( a_msb_q &  b_msb_q & ~res_next[MSB]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            o_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            s_q         <= s_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            o_q         <= o_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_q;
    assign bus.z_flag    = z_q;
    assign bus.n_flag    = n_q;
    assign bus.O         = o_q;

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Randomised self-checking bench for addsub_serial_unit at 32/8, 16/16 and 12/4.
module tb_addsub_serial_unit;
    import addsub_serial_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addsub_serial_unit_if #(.WIDTH(32)) bus32 ();
    addsub_serial_unit_if #(.WIDTH(16)) bus16 ();
    addsub_serial_unit_if #(.WIDTH(12)) bus12 ();

    addsub_serial_unit #(.WIDTH(32), .SLICE(8))  u32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    addsub_serial_unit #(.WIDTH(16), .SLICE(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    addsub_serial_unit #(.WIDTH(12), .SLICE(4))  u12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

    function automatic int width_of(input int u);
        return (u == 0) ? 32 : (u == 1) ? 16 : 12;
    endfunction

    function automatic int nsl_of(input int u);
        return (u == 0) ? 4 : (u == 1) ? 1 : 3;
    endfunction

    // Reference: arithmetic on the conditioned operands; flags packed {C,Z,N,O}
    function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] f, output logic [31:0] s,
                                      output logic [3:0] fl);
        longint unsigned m, ap, bp, cin, sum;
        longint sa, sb, tot, half;
        m    = (64'd1 << w) - 64'd1;
        half = longint'(64'd1 << (w - 1));
        case (f)
            F_ADD:   begin ap = 64'(a); bp = 64'(b);  cin = 0; end
            F_SUB:   begin ap = 64'(a); bp = 64'(~b); cin = 1; end
            F_NEG:   begin ap = 0;      bp = 64'(~b); cin = 1; end
            default: begin ap = 0;      bp = 64'(b);  cin = 1; end
        endcase
        ap  = ap & m;
        bp  = bp & m;
        sum = ap + bp + cin;
        s   = 32'(sum & m);
        sa  = (longint'(ap) >= half) ? longint'(ap) - 2 * half : longint'(ap);
        sb  = (longint'(bp) >= half) ? longint'(bp) - 2 * half : longint'(bp);
        tot = sa + sb + longint'(cin);
        fl[3] = ((sum >> w) & 64'd1) != 0;
        fl[2] = (s == 32'd0);
        fl[1] = ((sum >> (w - 1)) & 64'd1) != 0;
        fl[0] = (tot >= half) || (tot < -half);
    endfunction

    task automatic drive_in(input int u, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] f);
        case (u)
            0:       begin bus32.in_valid = v; bus32.a = a;        bus32.b = b;        bus32.f = f; end
            1:       begin bus16.in_valid = v; bus16.a = a[15:0];  bus16.b = b[15:0];  bus16.f = f; end
            default: begin bus12.in_valid = v; bus12.a = a[11:0];  bus12.b = b[11:0];  bus12.f = f; end
        endcase
    endtask

    task automatic set_ready(input int u, input logic r);
        case (u)
            0:       bus32.out_ready = r;
            1:       bus16.out_ready = r;
            default: bus12.out_ready = r;
        endcase
    endtask

    task automatic sample(input int u, output logic ov, output logic ir,
                          output logic [31:0] s, output logic [3:0] fl);
        case (u)
            0: begin
                ov = bus32.out_valid; ir = bus32.in_ready; s = bus32.s;
                fl = {bus32.c_out, bus32.z_flag, bus32.n_flag, bus32.O};
            end
            1: begin
                ov = bus16.out_valid; ir = bus16.in_ready; s = 32'(bus16.s);
                fl = {bus16.c_out, bus16.z_flag, bus16.n_flag, bus16.O};
            end
            default: begin
                ov = bus12.out_valid; ir = bus12.in_ready; s = 32'(bus12.s);
                fl = {bus12.c_out, bus12.z_flag, bus12.n_flag, bus12.O};
            end
        endcase
    endtask

    // Present one op, scramble inputs after accept, wait (bounded) for out_valid
    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] f, input bit take, output logic [31:0] s,
                          output logic [3:0] fl, output int lat);
        logic ov, ir;
        drive_in(u, 1'b1, a, b, f);
        @(posedge clk); #1;
        drive_in(u, 1'b0, $urandom, $urandom, 2'($urandom));
        lat = 0;
        sample(u, ov, ir, s, fl);
        while (!ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            sample(u, ov, ir, s, fl);
        end
        if (!ov) lat = -1;
        if (take) begin
            set_ready(u, 1'b1);
            @(posedge clk); #1;
            set_ready(u, 1'b0);
        end
    endtask

    task automatic test_reset();
        logic ov, ir;
        logic [31:0] s;
        logic [3:0] fl;
        for (int u = 0; u < 3; u++) begin
            sample(u, ov, ir, s, fl);
            checks++;
            if ({ov, ir} !== 2'b01) begin
                errors++;
                $display("FAIL reset_hs unit%0d out_valid/in_ready=%b%b required 01", u, ov, ir);
            end
            checks++;
            if (s !== 32'd0 || fl !== 4'd0) begin
                errors++;
                $display("FAIL reset_out unit%0d s=%h flags=%b required s=0 flags=0000", u, s, fl);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [7] = '{32'd5, 32'd3, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF};
        logic [31:0] vb [7] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF};
        logic [1:0]  vf [7] = '{F_ADD, F_SUB, F_SUB, F_ADD, F_SUB, F_NEG, F_INC};
        logic [31:0] vs [7] = '{32'd8, 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [3:0]  vl [7] = '{4'b0000, 4'b1100, 4'b0010, 4'b0011, 4'b1001, 4'b0010, 4'b1100};
        logic [31:0] s;
        logic [3:0] fl;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(0, va[i], vb[i], vf[i], 1'b1, s, fl, lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL dir_latency #%0d edges=%0d required 4", i, lat);
            end
            checks++;
            if (s !== vs[i] || fl !== vl[i]) begin
                errors++;
                $display("FAIL dir_result #%0d s=%h flags=%b required s=%h flags=%b", i, s, fl, vs[i], vl[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] s0, s, es;
        logic [3:0] fl0, fl, el;
        logic ov, ir;
        int lat;
        run_op(0, 32'h12345678, 32'h11111111, F_ADD, 1'b0, s0, fl0, lat);
        ref_model(32, 32'h12345678, 32'h11111111, F_ADD, es, el);
        checks++;
        if (lat !== 4 || s0 !== es || fl0 !== el) begin
            errors++;
            $display("FAIL hold_first lat=%0d s=%h flags=%b required lat=4 s=%h flags=%b", lat, s0, fl0, es, el);
        end
        for (int i = 0; i < 10; i++) begin
            drive_in(0, 1'(i % 2), $urandom, $urandom, 2'($urandom));
            @(posedge clk); #1;
            sample(0, ov, ir, s, fl);
            checks++;
            if (ov !== 1'b1 || ir !== 1'b0 || s !== s0 || fl !== fl0) begin
                errors++;
                $display("FAIL hold_stable cyc%0d ov=%b ir=%b s=%h flags=%b required ov=1 ir=0 s=%h flags=%b",
                         i, ov, ir, s, fl, s0, fl0);
            end
        end
        drive_in(0, 1'b0, 32'd0, 32'd0, F_ADD);
        set_ready(0, 1'b1);
        @(posedge clk); #1;
        set_ready(0, 1'b0);
        sample(0, ov, ir, s, fl);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1 || s !== s0 || fl !== fl0) begin
            errors++;
            $display("FAIL hold_release ov=%b ir=%b s=%h required ov=0 ir=1 s=%h", ov, ir, s, s0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s, es, a, b;
        logic [3:0] fl, el;
        logic ov, ir;
        int lat;
        logic [1:0] f;
        run_op(0, 32'hFFFF0000, 32'h00001234, F_ADD, 1'b1, s, fl, lat);
        drive_in(0, 1'b1, 32'h0F0F0F0F, 32'h01010101, F_SUB);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 32'd0, 32'd0, F_ADD);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sample(0, ov, ir, s, fl);
        checks++;
        if (ov !== 1'b0 || s !== 32'd0 || fl !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset ov=%b s=%h flags=%b required ov=0 s=0 flags=0000", ov, s, fl);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        sample(0, ov, ir, s, fl);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL midrun_discard ov=%b ir=%b required ov=0 ir=1", ov, ir);
        end
        a = $urandom; b = $urandom; f = 2'($urandom);
        run_op(0, a, b, f, 1'b1, s, fl, lat);
        ref_model(32, a, b, f, es, el);
        checks++;
        if (lat !== 4 || s !== es || fl !== el) begin
            errors++;
            $display("FAIL midrun_next lat=%0d s=%h flags=%b required lat=4 s=%h flags=%b", lat, s, fl, es, el);
        end
    endtask

    // Random ops on one unit; operand corners mixed in to hit carries and overflow
    task automatic test_random(input int u, input int n);
        logic [31:0] a, b, s, es;
        logic [3:0] fl, el;
        logic [1:0] f;
        int lat, w;
        w = width_of(u);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = 32'hFFFFFFFF >> (32 - w - 1);
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            f = 2'($urandom);
            run_op(u, a, b, f, 1'b1, s, fl, lat);
            ref_model(w, a, b, f, es, el);
            checks++;
            if (lat !== nsl_of(u) || s !== es || fl !== el) begin
                errors++;
                $display("FAIL rand_u%0d #%0d a=%h b=%h f=%0d lat=%0d s=%h flags=%b required lat=%0d s=%h flags=%b",
                         u, i, a, b, f, lat, s, fl, nsl_of(u), es, el);
            end
        end
    endtask

    task automatic test_sweep();
        test_random(1, 30);
        test_random(2, 30);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            drive_in(u, 1'b0, 32'd0, 32'd0, F_ADD);
            set_ready(u, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random(0, 40);
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
